// File: rtl/io_responder_pkg.sv
// Shared register map for the I/O responder.
// Offsets within the 4-byte window plus STATUS/CTRL bit positions.
package io_responder_pkg;

   localparam logic [1:0] IO_TXDATA = 2'd0;
   localparam logic [1:0] IO_STATUS = 2'd1;
   localparam logic [1:0] IO_RXDATA = 2'd2;
   localparam logic [1:0] IO_CTRL   = 2'd3;

   localparam int ST_TX_EMPTY = 0;
   localparam int ST_TX_FULL  = 1;
   localparam int ST_RX_AVAIL = 2;
   localparam int ST_TX_OVF   = 3;
   localparam int ST_RX_UNF   = 4;
   localparam int ST_CNT_LSB  = 5;

   localparam int CTRL_FLUSH = 0;
   localparam int CTRL_CLR   = 1;

endpackage

// File: rtl/io_fifo.sv
// Synchronous power-of-two FIFO with flush.
// Storage is not reset; only pointers and count are.
module io_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          empty,
   output logic          full,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign dout    = mem[rd_ptr];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Storage write; a full FIFO accepts only alongside a pop.
   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr_ptr] <= din;
   end

   // Pointer and occupancy tracking; flush overrides everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O responder: TX FIFO, RX holding register,
// sticky error flags and a RAM-matched one-cycle read return.
module io_responder
   import io_responder_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR = 8'hF0,
   parameter int         TX_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   input  logic       rden,
   input  logic       wren,
   output logic [7:0] rdata,
   output logic       rhit,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready
);

   localparam int CW = $clog2(TX_DEPTH) + 1;

   logic          hit;
   logic [1:0]    off;
   logic          wr;
   logic          rd;
   logic          push;
   logic          pop;
   logic          flush;
   logic          clr;
   logic          empty;
   logic          full;
   logic [CW-1:0] count;
   logic [7:0]    cnt8;
   logic [2:0]    cnt_sat;
   logic [7:0]    status;
   logic [7:0]    rd_mux;
   logic [7:0]    rx_hold;
   logic          rx_avail;
   logic          tx_ovf;
   logic          rx_unf;

   assign hit   = (addr[7:2] == BASE_ADDR[7:2]);
   assign off   = addr[1:0];
   assign wr    = wren & hit;
   assign rd    = rden & ~wren & hit;
   assign push  = wr & (off == IO_TXDATA);
   assign pop   = tx_valid & tx_ready;
   assign flush = wr & (off == IO_CTRL) & wdata[CTRL_FLUSH];
   assign clr   = wr & (off == IO_CTRL) & wdata[CTRL_CLR];

   assign tx_valid = ~empty;
   assign rx_ready = ~rx_avail;

   io_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (wdata),
      .dout  (tx_data),
      .empty (empty),
      .full  (full),
      .count (count)
   );

   assign cnt8    = 8'(count);
   assign cnt_sat = (cnt8 > 8'd7) ? 3'd7 : cnt8[2:0];

   // STATUS image assembled from live state.
   always_comb begin
      status                 = '0;
      status[ST_TX_EMPTY]    = empty;
      status[ST_TX_FULL]     = full;
      status[ST_RX_AVAIL]    = rx_avail;
      status[ST_TX_OVF]      = tx_ovf;
      status[ST_RX_UNF]      = rx_unf;
      status[ST_CNT_LSB+:3]  = cnt_sat;
   end

   // Read data select by offset; write-only/control reads return zero.
   always_comb begin
      rd_mux = '0;
      unique case (off)
         IO_STATUS: rd_mux = status;
         IO_RXDATA: rd_mux = rx_avail ? rx_hold : 8'h00;
         default:   rd_mux = 8'h00;
      endcase
   end

   // Read return: one-cycle pulse after an accepted read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
         rhit  <= 1'b0;
      end else begin
         rhit  <= rd;
         rdata <= rd ? rd_mux : 8'h00;
      end
   end

   // RX holding register; CPU pop and producer load are exclusive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_avail <= 1'b0;
         rx_hold  <= '0;
      end else if (rd && off == IO_RXDATA && rx_avail) begin
         rx_avail <= 1'b0;
      end else if (rx_valid && !rx_avail) begin
         rx_avail <= 1'b1;
         rx_hold  <= rx_data;
      end
   end

   // Sticky error flags, cleared through CTRL.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_ovf <= 1'b0;
         rx_unf <= 1'b0;
      end else begin
         if (clr) begin
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
         end
         if (push && full && !pop)
            tx_ovf <= 1'b1;
         if (rd && off == IO_RXDATA && !rx_avail)
            rx_unf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder with read and TX scoreboards.
// Expected values are derived from the register map by hand.
module tb_io_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic       rden;
   logic       wren;
   logic [7:0] rdata;
   logic       rhit;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   int total = 0;
   int bad   = 0;

   logic [8:0] rdq [$];
   logic [7:0] txq [$];

   io_responder #(.BASE_ADDR(8'hF0), .TX_DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .wdata    (wdata),
      .rden     (rden),
      .wren     (wren),
      .rdata    (rdata),
      .rhit     (rhit),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
      addr  = a;
      wdata = d;
      wren  = 1'b1;
      cyc();
      wren  = 1'b0;
   endtask

   task automatic bus_rd(input string tag, input logic [7:0] a,
                         input logic h, input logic [7:0] d);
      logic [8:0] e;
      rdq.push_back({h, d});
      addr = a;
      rden = 1'b1;
      cyc();
      rden = 1'b0;
      e = rdq.pop_front();
      chk({tag, "_rhit"}, {7'd0, rhit}, {7'd0, e[8]});
      chk({tag, "_rdata"}, rdata, e[7:0]);
   endtask

   task automatic drain(input string tag, input int n);
      tx_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         chk({tag, "_valid"}, {7'd0, tx_valid}, 8'd1);
         chk({tag, "_data"}, tx_data, txq.pop_front());
         cyc();
      end
      tx_ready = 1'b0;
      chk({tag, "_empty"}, {7'd0, tx_valid}, 8'd0);
   endtask

   initial begin
      rst      = 1'b1;
      addr     = 8'h00;
      wdata    = 8'h00;
      rden     = 1'b0;
      wren     = 1'b0;
      tx_ready = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      cyc();
      cyc();
      chk("rst_rhit", {7'd0, rhit}, 8'd0);
      chk("rst_rdata", rdata, 8'h00);
      chk("rst_txv", {7'd0, tx_valid}, 8'd0);
      chk("rst_rxr", {7'd0, rx_ready}, 8'd1);
      rst = 1'b0;
      cyc();

      // 1: status after reset
      bus_rd("s1_stat", 8'hF1, 1'b1, 8'h01);
      chk("s1_rxr", {7'd0, rx_ready}, 8'd1);
      chk("s1_txv", {7'd0, tx_valid}, 8'd0);
      cyc();
      chk("s1_rhit_drop", {7'd0, rhit}, 8'd0);
      chk("s1_rdata_drop", rdata, 8'h00);

      // 2: fill, overflow, drain in order
      for (int i = 1; i <= 4; i++) begin
         bus_wr(8'hF0, 8'(i * 8'h11));
         txq.push_back(8'(i * 8'h11));
      end
      bus_wr(8'hF0, 8'h55);
      bus_rd("s2_stat", 8'hF1, 1'b1, 8'h8A);
      bus_rd("s2_txd", 8'hF0, 1'b1, 8'h00);
      drain("s2_drain", 4);
      bus_wr(8'hF3, 8'h02);
      bus_rd("s2_clr", 8'hF1, 1'b1, 8'h01);

      // 3: push into full FIFO alongside a pop
      for (int i = 1; i <= 4; i++) begin
         bus_wr(8'hF0, 8'(i * 8'h11));
         txq.push_back(8'(i * 8'h11));
      end
      tx_ready = 1'b1;
      addr     = 8'hF0;
      wdata    = 8'h66;
      wren     = 1'b1;
      chk("s3_pop", tx_data, txq.pop_front());
      txq.push_back(8'h66);
      cyc();
      wren     = 1'b0;
      tx_ready = 1'b0;
      bus_rd("s3_stat", 8'hF1, 1'b1, 8'h82);
      drain("s3_drain", 4);

      // 4: RX hold, pop and underflow
      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      cyc();
      rx_valid = 1'b0;
      chk("s4_rxr_low", {7'd0, rx_ready}, 8'd0);
      bus_rd("s4_stat", 8'hF1, 1'b1, 8'h05);
      bus_rd("s4_rx", 8'hF2, 1'b1, 8'hA5);
      chk("s4_rxr_high", {7'd0, rx_ready}, 8'd1);
      bus_rd("s4_unf", 8'hF2, 1'b1, 8'h00);
      bus_rd("s4_stat2", 8'hF1, 1'b1, 8'h11);

      // 5: CTRL flush and clear, miss address
      for (int i = 1; i <= 3; i++)
         bus_wr(8'hF0, 8'(i));
      bus_rd("s5_pre", 8'hF1, 1'b1, 8'h70);
      bus_wr(8'hF3, 8'h03);
      bus_rd("s5_post", 8'hF1, 1'b1, 8'h01);
      bus_rd("s5_ctrl", 8'hF3, 1'b1, 8'h00);
      bus_rd("s5_miss", 8'h40, 1'b0, 8'h00);

      // 6: async reset mid-operation
      bus_wr(8'hF0, 8'hC1);
      bus_wr(8'hF0, 8'hC2);
      addr = 8'hF1;
      rden = 1'b1;
      cyc();
      chk("s6_pend", {7'd0, rhit}, 8'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("s6_async_rhit", {7'd0, rhit}, 8'd0);
      chk("s6_async_txv", {7'd0, tx_valid}, 8'd0);
      rden = 1'b0;
      cyc();
      rst = 1'b0;
      cyc();
      bus_rd("s6_stat", 8'hF1, 1'b1, 8'h01);
      addr  = 8'hF0;
      wdata = 8'h77;
      wren  = 1'b1;
      rden  = 1'b1;
      cyc();
      wren  = 1'b0;
      rden  = 1'b0;
      chk("s6_both_rhit", {7'd0, rhit}, 8'd0);
      bus_rd("s6_both_stat", 8'hF1, 1'b1, 8'h20);
      txq.push_back(8'h77);
      drain("s6_drain", 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
